// File: rtl/ed25519_io_ctrl.sv
// rtl/ed25519_io_ctrl.sv - stream front-end sequencer for the ed25519 scalar-multiplication core
module ed25519_io_ctrl #(
  parameter int DATA_W = 64,
  parameter int PATN_W = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_start,
  output logic [PATN_W-1:0] o_scalar,
  output logic [PATN_W-1:0] o_px,
  output logic [PATN_W-1:0] o_py,
  input  logic              i_done,
  input  logic [PATN_W-1:0] i_rx,
  input  logic [PATN_W-1:0] i_ry,
  output logic              o_busy
);

  localparam int IN_WORDS  = 3 * PATN_W / DATA_W;
  localparam int OUT_WORDS = 2 * PATN_W / DATA_W;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_ready_q;
  logic [3*PATN_W-1:0]     op_q;
  logic [2*PATN_W-1:0]     out_q;
  logic                    in_fire;
  logic                    out_fire;

  // in_ready_q is only ever set while in LOAD; the state term keeps the handshake explicit
  assign in_fire  = i_in_valid && in_ready_q && (state_q == S_LOAD);
  assign out_fire = (state_q == S_UNLOAD) && i_out_ready;

  // Next-state and shared word counter (input words in LOAD, output words in UNLOAD)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          if (cnt_q == CNT_W'(IN_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (i_done) state_d = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (out_fire) begin
          if (cnt_q == CNT_W'(OUT_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered input-ready (low during reset, high whenever the next state is LOAD)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == S_LOAD);
    end
  end

  // Operand deserializer shifts words in from the bottom so word 0 lands in scalar[255:192];
  // result serializer captures {x,y} on done and shifts left one word per output transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q  <= '0;
      out_q <= '0;
    end else begin
      if (in_fire) begin
        op_q <= {op_q[3*PATN_W-DATA_W-1:0], i_in_data};
      end
      if ((state_q == S_WAIT) && i_done) begin
        out_q <= {i_rx, i_ry};
      end else if (out_fire) begin
        out_q <= out_q << DATA_W;
      end
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_start     = (state_q == S_START);
  assign o_out_valid = (state_q == S_UNLOAD);
  assign o_busy      = (state_q != S_LOAD);
  assign o_out_data  = out_q[2*PATN_W-1 -: DATA_W];
  assign o_scalar    = op_q[3*PATN_W-1 -: PATN_W];
  assign o_px        = op_q[2*PATN_W-1 -: PATN_W];
  assign o_py        = op_q[PATN_W-1:0];

endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// tb/tb_ed25519_io_ctrl.sv - self-checking bench for ed25519_io_ctrl with a word-level reference model
module tb_ed25519_io_ctrl;

  localparam int DATA_W = 64;
  localparam int PATN_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              start;
  logic [PATN_W-1:0] scalar, px, py;
  logic              done;
  logic [PATN_W-1:0] rx, ry;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  ed25519_io_ctrl #(.DATA_W(DATA_W), .PATN_W(PATN_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data),
    .o_start    (start),
    .o_scalar   (scalar),
    .o_px       (px),
    .o_py       (py),
    .i_done     (done),
    .i_rx       (rx),
    .i_ry       (ry),
    .o_busy     (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [PATN_W-1:0] got, input logic [PATN_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PATN_W-1:0] rand256();
    logic [PATN_W-1:0] v;
    for (int k = 0; k < PATN_W / 32; k++) v = {v[PATN_W-33:0], $urandom()};
    return v;
  endfunction

  // Asynchronous reset issued mid-cycle; released mid-cycle one edge later
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    done      = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_start", start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_scalar", scalar, 0);
    check_val("rst_px", px, 0);
    check_val("rst_py", py, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check_val("rst_rel_in_ready", in_ready, 0);
    tick();
    check_val("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic run_pattern(input bit basic, input int vpct, input int rpct, input int hold,
                             input bit stray, input int abort_in, input int abort_out);
    logic [DATA_W-1:0]   w[12];
    logic [PATN_W-1:0]   ex, ey;
    logic [3*PATN_W-1:0] ops;
    logic [2*PATN_W-1:0] res;
    logic [DATA_W-1:0]   expq[$];
    int                  i, j, budget, cyc, st_cnt;
    bit                  fire;

    for (int k = 0; k < 12; k++)
      w[k] = basic ? 64'h1111_1111_1111_1111 * 64'(k + 1) : {$urandom(), $urandom()};
    ex = basic ? {4{64'hAAAA_AAAA_AAAA_AAAA}} : rand256();
    ey = basic ? {4{64'h5555_5555_5555_5555}} : rand256();
    ops = '0;
    for (int k = 0; k < 12; k++) ops[(11 - k) * DATA_W +: DATA_W] = w[k];
    res = {ex, ey};
    expq.delete();
    for (int k = 0; k < 8; k++) expq.push_back(res[(7 - k) * DATA_W +: DATA_W]);

    i = 0;
    budget = 0;
    while (i < 12) begin
      if (abort_in >= 0 && i == abort_in) begin
        do_reset();
        return;
      end
      in_valid = ($urandom_range(99) < vpct);
      in_data  = in_valid ? w[i] : {$urandom(), $urandom()};
      done     = stray && (i == 5);
      rx       = rand256();
      fire     = in_valid && in_ready;
      tick();
      if (fire) i++;
      budget++;
      if (budget > 2000) begin
        check_val("load_timeout", 0, 1);
        finish_tb();
        return;
      end
    end
    in_valid = 1'b1;
    in_data  = {$urandom(), $urandom()};
    done     = 1'b0;
    check_val("start_pulse", start, 1);
    check_val("start_busy", busy, 1);
    check_val("start_in_ready", in_ready, 0);
    check_val("op_scalar", scalar, ops[3*PATN_W-1 -: PATN_W]);
    check_val("op_px", px, ops[2*PATN_W-1 -: PATN_W]);
    check_val("op_py", py, ops[PATN_W-1:0]);

    st_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      st_cnt += int'(start);
      if (out_valid) st_cnt += 100;
    end
    in_valid = 1'b0;
    check_val("start_once_wait_quiet", st_cnt, 0);
    check_val("wait_busy", busy, 1);
    check_val("wait_in_ready", in_ready, 0);

    done = 1'b1;
    rx   = ex;
    ry   = ey;
    tick();
    done = 1'b0;
    rx   = ~ex;
    ry   = ~ey;
    check_val("done_to_valid", out_valid, 1);
    check_val("hold_op_scalar", scalar, ops[3*PATN_W-1 -: PATN_W]);

    j = 0;
    cyc = 0;
    while (j < 8) begin
      if (abort_out >= 0 && j == abort_out) begin
        do_reset();
        return;
      end
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rpct);
      done      = stray && (j == 3);
      check_val($sformatf("out_valid_w%0d", j), out_valid, 1);
      check_val($sformatf("out_data_w%0d", j), out_data, expq[j]);
      fire = out_ready;
      tick();
      cyc++;
      if (fire) j++;
      if (cyc > 2000) begin
        check_val("unload_timeout", 0, 1);
        finish_tb();
        return;
      end
    end
    out_ready = 1'b0;
    done      = 1'b0;
    if (hold == 0 && rpct == 100) check_val("unload_cycles", cyc, 8);
    if (hold > 0 && rpct == 100) check_val("hold_unload_cycles", cyc, hold + 8);
    check_val("end_out_valid", out_valid, 0);
    check_val("end_in_ready", in_ready, 1);
    check_val("end_busy", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    done      = 1'b0;
    rx        = '0;
    ry        = '0;
    do_reset();
    run_pattern(1, 100, 100, 0, 0, -1, -1);
    run_pattern(1, 50, 50, 0, 0, -1, -1);
    run_pattern(1, 100, 100, 10, 0, -1, -1);
    run_pattern(0, 70, 70, 0, 1, -1, -1);
    run_pattern(0, 100, 100, 0, 0, -1, -1);
    run_pattern(0, 100, 100, 0, 0, -1, -1);
    run_pattern(0, 100, 100, 0, 0, 6, -1);
    run_pattern(0, 60, 60, 0, 0, -1, -1);
    run_pattern(0, 100, 100, 0, 0, -1, 3);
    run_pattern(0, 100, 100, 0, 0, -1, -1);
    for (int n = 0; n < 4; n++) run_pattern(0, 50, 50, $urandom_range(3), 1, -1, -1);
    finish_tb();
  end

endmodule
